// File: rtl/saturn_pc_rstk_stack.sv
// saturn_pc_rstk_stack
// PC register, serial jump-operand assembler and circular return stack for
// the Saturn core. The decoder feeds jump operands one nibble at a time
// (least-significant first); the unit raises o_reload_pc whenever the fetch
// pipeline must be flushed and restarted from o_pc.
//
// Optional feature: define SATURN_RSTK_DBG_EN to add the i_dbg_idx/o_dbg_val
// read-only window into the return stack (index 0 = top of stack).
//
// FSM states
//   state  | meaning
//   IDLE   | normal sequencing; stack operations and PC increment accepted
//   DECODE | collecting operand nibbles for a pending jump
//   EXEC   | operand complete; PC loaded (and GOSUB push) on the next step
module saturn_pc_rstk_stack #(
    parameter int  ADDR_W     = 20,
    parameter int  RSTK_DEPTH = 8,
    localparam int PTR_W      = $clog2(RSTK_DEPTH),
    localparam int NIBS       = ADDR_W / 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clk_en,
    input  logic              i_stall,
    input  logic              i_inc_pc,
    input  logic              i_jump_start,
    input  logic [2:0]        i_jump_len,
    input  logic              i_jump_rel,
    input  logic              i_jump_push,
    input  logic              i_nib_valid,
    input  logic [3:0]        i_nibble,
    input  logic              i_rtn,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_reload_pc,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_pop_data,
    output logic [PTR_W:0]    o_rstk_count,
    output logic              o_rstk_ovf,
`ifdef SATURN_RSTK_DBG_EN
    input  logic [PTR_W-1:0]  i_dbg_idx,
    output logic [ADDR_W-1:0] o_dbg_val,
`endif
    output logic              o_rstk_unf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(RSTK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RSTK_DEPTH - 1);
    localparam logic [3:0]       NIBS_L  = 4'(NIBS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   off_q, off_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                reload_q, reload_d;
    logic [ADDR_W-1:0]   pop_data_q, pop_data_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [ADDR_W-1:0]   rstk_q [RSTK_DEPTH];
    logic [ADDR_W-1:0]   rstk_d [RSTK_DEPTH];

    logic                step;
    logic                stk_empty;
    logic [ADDR_W-1:0]   top_val;
    logic [3:0]          len_req;
    logic                sign_bit;
    logic [ADDR_W-1:0]   off_ext;
    logic                do_push;
    logic [ADDR_W-1:0]   push_val;

    assign step      = i_clk_en & ~i_stall;
    assign stk_empty = (count_q == '0);
    assign top_val   = stk_empty ? '0 : rstk_q[ptr_q];
    assign len_req   = ({1'b0, i_jump_len} > NIBS_L) ? NIBS_L : {1'b0, i_jump_len};

    // Sign-extend the assembled operand from its actual width (4*len bits).
    always_comb begin
        sign_bit = 1'b0;
        off_ext  = '0;
        for (int n = 1; n <= NIBS; n++) begin
            if (len_q == 4'(n)) begin
                sign_bit = off_q[4*n-1];
            end
        end
        for (int b = 0; b < ADDR_W; b++) begin
            off_ext[b] = (b >= 4 * int'(len_q)) ? sign_bit : off_q[b];
        end
    end

    // Next-state for FSM, PC, operand assembler and return stack.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        base_d     = base_q;
        off_d      = off_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        pop_data_d = pop_data_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        rstk_d     = rstk_q;
        do_push    = 1'b0;
        push_val   = '0;

        if (step) begin
            reload_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_jump_start && (i_jump_len != 3'd0)) begin
                        base_d  = pc_q;
                        len_d   = len_req;
                        off_d   = '0;
                        cnt_d   = '0;
                        state_d = DECODE;
                    end else if (i_rtn) begin
                        pc_d     = top_val;
                        reload_d = 1'b1;
                        if (stk_empty) begin
                            unf_d = 1'b1;
                        end else begin
                            rstk_d[ptr_q] = '0;
                            count_d       = count_q - (PTR_W+1)'(1);
                            ptr_d         = ptr_q - PTR_W'(1);
                        end
                    end else if (i_pop && i_push) begin
                        // Exchange: top replaced in place, depth unchanged
                        // unless the stack was empty.
                        pop_data_d    = top_val;
                        rstk_d[ptr_q] = i_push_data;
                        if (stk_empty) begin
                            count_d = (PTR_W+1)'(1);
                            unf_d   = 1'b1;
                        end
                    end else if (i_pop) begin
                        pop_data_d = top_val;
                        if (stk_empty) begin
                            unf_d = 1'b1;
                        end else begin
                            rstk_d[ptr_q] = '0;
                            count_d       = count_q - (PTR_W+1)'(1);
                            ptr_d         = ptr_q - PTR_W'(1);
                        end
                    end else if (i_push) begin
                        do_push  = 1'b1;
                        push_val = i_push_data;
                    end else if (i_inc_pc) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
                DECODE: begin
                    if (i_inc_pc) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                    if (i_nib_valid) begin
                        for (int n = 0; n < NIBS; n++) begin
                            if (cnt_q == 4'(n)) begin
                                off_d[4*n +: 4] = i_nibble;
                            end
                        end
                        cnt_d = cnt_q + 4'd1;
                        if ((cnt_q + 4'd1) == len_q) begin
                            state_d  = EXEC;
                            reload_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    pc_d = i_jump_rel ? (base_q + off_ext) : off_q;
                    if (i_jump_push) begin
                        do_push  = 1'b1;
                        push_val = pc_q;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Circular push: when full, the pointer lands on the oldest entry.
            if (do_push) begin
                ptr_d         = ptr_q + PTR_W'(1);
                rstk_d[ptr_d] = push_val;
                if (count_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + (PTR_W+1)'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            base_q     <= '0;
            off_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            reload_q   <= 1'b0;
            pop_data_q <= '0;
            count_q    <= '0;
            ptr_q      <= PTR_MAX;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            for (int i = 0; i < RSTK_DEPTH; i++) begin
                rstk_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            base_q     <= base_d;
            off_q      <= off_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            pop_data_q <= pop_data_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rstk_q     <= rstk_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_reload_pc  = reload_q;
    assign o_busy       = (state_q != IDLE);
    assign o_pop_data   = pop_data_q;
    assign o_rstk_count = count_q;
    assign o_rstk_ovf   = ovf_q;
    assign o_rstk_unf   = unf_q;

`ifdef SATURN_RSTK_DBG_EN
    // Read-only view; the subtraction wraps modulo the (power-of-two) depth.
    assign o_dbg_val = rstk_q[ptr_q - i_dbg_idx];
`endif

endmodule

// File: tb/tb_saturn_pc_rstk_stack.sv
// Directed bench for saturn_pc_rstk_stack (ADDR_W=20, RSTK_DEPTH=8).
module tb_saturn_pc_rstk_stack;

    localparam int ADDR_W = 20;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = $clog2(DEPTH);

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_clk_en = 1'b1;
    logic              i_stall = 1'b0;
    logic              i_inc_pc = 1'b0;
    logic              i_jump_start = 1'b0;
    logic [2:0]        i_jump_len = 3'd0;
    logic              i_jump_rel = 1'b0;
    logic              i_jump_push = 1'b0;
    logic              i_nib_valid = 1'b0;
    logic [3:0]        i_nibble = 4'd0;
    logic              i_rtn = 1'b0;
    logic              i_push = 1'b0;
    logic [ADDR_W-1:0] i_push_data = '0;
    logic              i_pop = 1'b0;
    logic [ADDR_W-1:0] o_pc;
    logic              o_reload_pc;
    logic              o_busy;
    logic [ADDR_W-1:0] o_pop_data;
    logic [PTR_W:0]    o_rstk_count;
    logic              o_rstk_ovf;
    logic              o_rstk_unf;
`ifdef SATURN_RSTK_DBG_EN
    logic [PTR_W-1:0]  i_dbg_idx = '0;
    logic [ADDR_W-1:0] o_dbg_val;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    saturn_pc_rstk_stack #(.ADDR_W(ADDR_W), .RSTK_DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clk_en     (i_clk_en),
        .i_stall      (i_stall),
        .i_inc_pc     (i_inc_pc),
        .i_jump_start (i_jump_start),
        .i_jump_len   (i_jump_len),
        .i_jump_rel   (i_jump_rel),
        .i_jump_push  (i_jump_push),
        .i_nib_valid  (i_nib_valid),
        .i_nibble     (i_nibble),
        .i_rtn        (i_rtn),
        .i_push       (i_push),
        .i_push_data  (i_push_data),
        .i_pop        (i_pop),
        .o_pc         (o_pc),
        .o_reload_pc  (o_reload_pc),
        .o_busy       (o_busy),
        .o_pop_data   (o_pop_data),
        .o_rstk_count (o_rstk_count),
        .o_rstk_ovf   (o_rstk_ovf),
`ifdef SATURN_RSTK_DBG_EN
        .i_dbg_idx    (i_dbg_idx),
        .o_dbg_val    (o_dbg_val),
`endif
        .o_rstk_unf   (o_rstk_unf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Full jump: start, n_nibs operand nibbles, then the EXEC step.
    task automatic do_jump(input logic [2:0] len, input int n_nibs, input logic rel,
                           input logic push, input logic [31:0] nibs);
        i_jump_start = 1'b1;
        i_jump_len   = len;
        i_jump_rel   = rel;
        i_jump_push  = push;
        tick();
        i_jump_start = 1'b0;
        for (int k = 0; k < n_nibs; k++) begin
            i_nib_valid = 1'b1;
            i_nibble    = nibs[4*k +: 4];
            tick();
        end
        i_nib_valid = 1'b0;
        check("reload_after_operand", 32'(o_reload_pc), 32'd1);
        tick();
        check("exec_reload_clear", 32'(o_reload_pc), 32'd0);
        i_jump_rel  = 1'b0;
        i_jump_push = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_pc", 32'(o_pc), 32'h0);
        check("rst_count", 32'(o_rstk_count), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_flags", {30'd0, o_rstk_ovf, o_rstk_unf}, 32'd0);
        check("rst_pop_data", 32'(o_pop_data), 32'h0);
        i_reset_n = 1'b1;

        // Three increments
        i_inc_pc = 1'b1;
        repeat (3) tick();
        i_inc_pc = 1'b0;
        check("inc3_pc", 32'(o_pc), 32'h00003);
        check("inc3_count", 32'(o_rstk_count), 32'd0);
        check("inc3_reload", 32'(o_reload_pc), 32'd0);

        // Absolute jump to 0x100, then relative -2
        do_jump(3'd3, 3, 1'b0, 1'b0, 32'h100);
        check("abs_pc_100", 32'(o_pc), 32'h00100);
        do_jump(3'd3, 3, 1'b1, 1'b0, 32'hFFE);
        check("rel_minus2_pc", 32'(o_pc), 32'h000FE);

        // Length above NIBS clamps to 5 nibbles
        do_jump(3'd7, 5, 1'b0, 1'b0, 32'hABCDE);
        check("clamp_pc", 32'(o_pc), 32'hABCDE);
        check("clamp_busy", 32'(o_busy), 32'd0);

        // Zero length ignored
        i_jump_start = 1'b1;
        i_jump_len   = 3'd0;
        tick();
        i_jump_start = 1'b0;
        check("len0_busy", 32'(o_busy), 32'd0);
        check("len0_pc", 32'(o_pc), 32'hABCDE);

        // GOSUB and return
        do_jump(3'd5, 5, 1'b0, 1'b0, 32'h12345);
        do_jump(3'd5, 5, 1'b0, 1'b1, 32'h08000);
        check("gosub_pc", 32'(o_pc), 32'h08000);
        check("gosub_count", 32'(o_rstk_count), 32'd1);
        i_rtn = 1'b1;
        tick();
        i_rtn = 1'b0;
        check("rtn_pc", 32'(o_pc), 32'h12345);
        check("rtn_count", 32'(o_rstk_count), 32'd0);
        check("rtn_reload", 32'(o_reload_pc), 32'd1);
        tick();
        check("rtn_reload_pulse", 32'(o_reload_pc), 32'd0);

        // PC wrap and relative wrap
        do_jump(3'd5, 5, 1'b0, 1'b0, 32'hFFFFF);
        i_inc_pc = 1'b1;
        tick();
        i_inc_pc = 1'b0;
        check("inc_wrap", 32'(o_pc), 32'h00000);
        do_jump(3'd5, 5, 1'b0, 1'b0, 32'hFFFFF);
        do_jump(3'd1, 1, 1'b1, 1'b0, 32'h3);
        check("rel_wrap", 32'(o_pc), 32'h00002);

        // Overflow: 9 pushes into 8 entries
        i_push = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            i_push_data = ADDR_W'(k);
            tick();
        end
        i_push = 1'b0;
        check("ovf_count", 32'(o_rstk_count), 32'd8);
        check("ovf_flag", 32'(o_rstk_ovf), 32'd1);
        check("ovf_no_unf", 32'(o_rstk_unf), 32'd0);
        i_pop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("pop_seq", 32'(o_pop_data), 32'(9 - k));
        end
        tick();
        i_pop = 1'b0;
        check("pop_empty_data", 32'(o_pop_data), 32'h0);
        check("pop_empty_unf", 32'(o_rstk_unf), 32'd1);
        check("pop_empty_count", 32'(o_rstk_count), 32'd0);

        // Exchange
        i_push = 1'b1;
        i_push_data = 20'hAAAAA;
        tick();
        i_pop = 1'b1;
        i_push_data = 20'h55555;
        tick();
        i_push = 1'b0;
        check("xchg_pop_data", 32'(o_pop_data), 32'hAAAAA);
        check("xchg_count", 32'(o_rstk_count), 32'd1);
        tick();
        i_pop = 1'b0;
        check("xchg_new_top", 32'(o_pop_data), 32'h55555);
        check("xchg_drained", 32'(o_rstk_count), 32'd0);
        i_push = 1'b1;
        i_pop  = 1'b1;
        i_push_data = 20'h77777;
        tick();
        i_push = 1'b0;
        check("xchg_empty_data", 32'(o_pop_data), 32'h0);
        check("xchg_empty_count", 32'(o_rstk_count), 32'd1);
        tick();
        i_pop = 1'b0;
        check("xchg_empty_top", 32'(o_pop_data), 32'h77777);

        // Stall mid-DECODE (PC is 2 here)
        i_jump_start = 1'b1;
        i_jump_len   = 3'd3;
        tick();
        i_jump_start = 1'b0;
        i_nib_valid  = 1'b1;
        i_nibble     = 4'h4;
        tick();
        i_stall  = 1'b1;
        i_inc_pc = 1'b1;
        i_nibble = 4'hF;
        repeat (4) tick();
        check("stall_pc", 32'(o_pc), 32'h00002);
        check("stall_busy", 32'(o_busy), 32'd1);
        check("stall_reload", 32'(o_reload_pc), 32'd0);
        i_stall  = 1'b0;
        i_inc_pc = 1'b0;
        i_nibble = 4'h5;
        tick();
        check("stall_mid_reload", 32'(o_reload_pc), 32'd0);
        i_nibble = 4'h6;
        tick();
        i_nib_valid = 1'b0;
        check("stall_end_reload", 32'(o_reload_pc), 32'd1);
        tick();
        check("stall_exec_pc", 32'(o_pc), 32'h00654);

        // Asynchronous reset mid-DECODE
        i_jump_start = 1'b1;
        tick();
        i_jump_start = 1'b0;
        i_nib_valid  = 1'b1;
        i_nibble     = 4'h1;
        tick();
        i_nib_valid  = 1'b0;
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_pc", 32'(o_pc), 32'h0);
        check("arst_flags", {30'd0, o_rstk_ovf, o_rstk_unf}, 32'd0);
        tick();
        i_reset_n = 1'b1;

        // Return on empty stack
        i_inc_pc = 1'b1;
        repeat (2) tick();
        i_inc_pc = 1'b0;
        check("pre_rtn_pc", 32'(o_pc), 32'h00002);
        i_rtn = 1'b1;
        tick();
        i_rtn = 1'b0;
        check("rtn_empty_pc", 32'(o_pc), 32'h0);
        check("rtn_empty_unf", 32'(o_rstk_unf), 32'd1);
        check("rtn_empty_count", 32'(o_rstk_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/saturn_pc_rstk_stack.md
Name: saturn_pc_rstk_stack

Overview:
Parametrised PC and return-stack unit for the Saturn core, successor to the fixed 20-bit/8-level PC/RSTK block. It tracks PC and serially assembles nibble-wide jump operands with a 3-state FSM (absolute or sign-extended relative). It runs a circular return stack of configurable depth with occupancy tracking, oldest-entry drop on overflow, zero-return on underflow, and explicit push/pop/exchange ports for RSTK=C / C=RSTK. Sits between the instruction decoder and the bus fetch unit; o_reload_pc tells the fetcher to flush and refetch.

Parameters:
ADDR_W, 20, PC/RSTK entry width in bits; multiple of 4, range 8..32.
RSTK_DEPTH, 8, return-stack entries; power of two, range 2..64.
PTR_W, $clog2(RSTK_DEPTH), stack pointer width (derived).
NIBS, ADDR_W/4, maximum jump operand nibbles (derived).

Ports:
i_clk  in  1  clock, all state on rising edge.
i_reset_n  in  1  reset, asynchronous assert, active-low.
i_clk_en  in  1  global enable; no state changes when 0.
i_stall  in  1  bus/ALU busy; no state changes when 1.
i_inc_pc  in  1  advance PC by 1 (nibble fetched).
i_jump_start  in  1  begin jump operand decode.
i_jump_len  in  3  operand nibble count, 1..NIBS.
i_jump_rel  in  1  1 = PC-relative (sign-extended), 0 = absolute.
i_jump_push  in  1  push return address at jump execution (GOSUB).
i_nib_valid  in  1  i_nibble carries an operand nibble.
i_nibble  in  4  operand nibble, least-significant first.
i_rtn  in  1  return: PC <= top, pop.
i_push  in  1  push i_push_data.
i_push_data  in  ADDR_W  data for explicit push.
i_pop  in  1  pop top to o_pop_data.
o_pc  out  ADDR_W  current PC.
o_reload_pc  out  1  fetch pipeline must reload from o_pc.
o_busy  out  1  FSM not IDLE.
o_pop_data  out  ADDR_W  last popped value, registered.
o_rstk_count  out  PTR_W+1  valid entries, 0..RSTK_DEPTH.
o_rstk_ovf  out  1  sticky: a push dropped an entry.
o_rstk_unf  out  1  sticky: a pop/rtn hit an empty stack.

Behaviour:
- "Step" = rising edge with i_clk_en=1 and i_stall=0. Nothing updates outside a step.
- Reset (i_reset_n=0, asynchronous): PC=0, FSM=IDLE, count=0, ptr=RSTK_DEPTH-1, all entries 0, all outputs 0. Reset mid-decode discards the jump.
- FSM IDLE: on i_jump_start with i_jump_len!=0, capture base=PC, len=min(i_jump_len,NIBS), clear offset and nibble counter, go to DECODE. i_jump_len=0: ignored.
- DECODE: each step with i_nib_valid places i_nibble at bits [4k+3:4k] (k = counter), then increments counter. On the len-th nibble, go to EXEC and set o_reload_pc=1 in that same step.
- EXEC (next step): PC <= i_jump_rel ? base + sign-extend(offset, 4*len bits) : zero-extend(offset), modulo 2^ADDR_W. If i_jump_push, push the current PC (return address after the operand). o_reload_pc=0; go to IDLE.
- i_inc_pc is honoured in IDLE and DECODE and ignored in EXEC. Wrap: all-ones goes to 0.
- Stack operations (i_rtn, i_pop, i_push) are honoured only in IDLE and are ignored otherwise.
- Priority in IDLE: i_jump_start > i_rtn > i_pop/i_push > i_inc_pc. A lower-priority PC update is dropped in the same step.
- i_rtn: PC <= top (0 if empty), o_reload_pc pulses for 1 step, entry cleared, count--, ptr--. If empty, set o_rstk_unf and leave count/ptr unchanged.
- i_push (also GOSUB push): ptr++, write entry, count++ saturating at RSTK_DEPTH. If count was already full, the oldest entry is overwritten and o_rstk_ovf is set.
- i_pop: o_pop_data <= top (0 if empty); otherwise same as i_rtn but PC is untouched.
- i_pop and i_push together: exchange. o_pop_data <= old top and top <= i_push_data; count and ptr unchanged. If empty, o_pop_data=0, count becomes 1, and o_rstk_unf is set.
- Sticky flags clear only on reset.

Optional Feature:
SATURN_RSTK_DBG_EN: adds ports i_dbg_idx (PTR_W, in) and o_dbg_val (ADDR_W, out). o_dbg_val = entry at (ptr - i_dbg_idx) mod RSTK_DEPTH, combinational; index 0 is the top. It has no side effects. Without the macro, the ports do not exist.

Test Plan:
- Reset, then 3 i_inc_pc steps -> o_pc=0x00003, o_rstk_count=0, o_reload_pc=0.
- PC=0x00100; i_jump_start, len=3, rel; nibbles E,F,F -> offset 0xFFE sign-extends to -2. o_reload_pc=1 after the 3rd nibble. At EXEC, o_pc=0x000FE; o_reload_pc returns to 0.
- PC=0x12345; absolute GOSUB len=5, nibbles 0,0,0,8,0 -> o_pc=0x08000, count=1. Then i_rtn -> o_pc=0x12345, count=0.
- 9 pushes of 1..9 with DEPTH=8 -> count=8, o_rstk_ovf=1. 8 pops return 9,8,...,2; the 9th pop returns 0 and sets o_rstk_unf.
- Push 0xAAAAA, then i_push=i_pop=1 with 0x55555 -> o_pop_data=0xAAAAA, top=0x55555, count=1.
- Assert i_stall mid-DECODE for 4 cycles -> no nibble is consumed and PC is frozen. Assert i_reset_n=0 mid-DECODE -> immediately o_busy=0, o_pc=0.
